// File: rtl/bp_fe_fetch_queue.sv
// rtl/bp_fe_fetch_queue.sv - fetch packet decoupling FIFO between IF2 and the backend-facing FE queue
//
// Purpose:
//   Circular buffer of fetched packets (pc, instr, branch metadata, exception code).
//   Packets are presented in order at the dequeue side.
//   enq_ready_o is an early warning: it drops while skid_p entries are still free,
//   so the in-flight fetches can still land. Once an exception packet is accepted,
//   further fetches are dropped until a redirect (flush_i).
//
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   enq_*_i                        fetch packet from IF2 (enq_v_i qualifies)
//   enq_ready_o                    early-warning ready
//   deq_*_o                        head packet (deq_v_o qualifies)
//   deq_yumi_i                     head consumed this cycle
//   flush_i                        redirect: discard all contents, leave exception hold
//   count_o                        occupancy
//   overflow_o                     sticky: a packet was dropped because the queue was full
module bp_fe_fetch_queue #(
  parameter int vaddr_width_p               = 39,
  parameter int instr_width_p               = 32,
  parameter int branch_metadata_fwd_width_p = 64,
  parameter int els_p                       = 8,
  parameter int skid_p                      = 2
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   enq_v_i,
  input  logic [vaddr_width_p-1:0]               enq_pc_i,
  input  logic [instr_width_p-1:0]               enq_instr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] enq_br_metadata_fwd_i,
  input  logic [1:0]                             enq_exc_i,
  output logic                                   enq_ready_o,
  output logic                                   deq_v_o,
  output logic [vaddr_width_p-1:0]               deq_pc_o,
  output logic [instr_width_p-1:0]               deq_instr_o,
  output logic [branch_metadata_fwd_width_p-1:0] deq_br_metadata_fwd_o,
  output logic [1:0]                             deq_exc_o,
  input  logic                                   deq_yumi_i,
  input  logic                                   flush_i,
  output logic [$clog2(els_p+1)-1:0]             count_o,
  output logic                                   overflow_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p+1);

  typedef enum logic {e_run, e_exc_hold} state_e;

  state_e                 state_q;
  logic [ptr_w_lp-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0]    count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic [vaddr_width_p-1:0]               pc_mem_q    [els_p];
  logic [instr_width_p-1:0]               instr_mem_q [els_p];
  logic [branch_metadata_fwd_width_p-1:0] md_mem_q    [els_p];
  logic [1:0]                             exc_mem_q   [els_p];

  logic run, full, enq_fire, deq_fire, enq_drop_full;
  logic [cnt_w_lp-1:0] free;

  assign run           = (state_q == e_run);
  assign full          = (count_q == cnt_w_lp'(els_p));
  // Full is judged on the registered count, so a same-cycle dequeue does not make room.
  assign enq_fire      = enq_v_i & run & ~full & ~flush_i;
  assign enq_drop_full = enq_v_i & run &  full & ~flush_i;
  assign deq_fire      = deq_yumi_i;
  assign free          = cnt_w_lp'(els_p) - count_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q + ptr_w_lp'(deq_fire);
    wr_ptr_d   = wr_ptr_q + ptr_w_lp'(enq_fire);
    count_d    = count_q + cnt_w_lp'(enq_fire) - cnt_w_lp'(deq_fire);
    overflow_d = overflow_q | enq_drop_full;
    if (flush_i) begin
      // Any same-cycle dequeue still consumes the old head; everything else is discarded.
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= e_run;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      case (state_q)
        e_run:      if (enq_fire && (enq_exc_i != 2'b00)) state_q <= e_exc_hold;
        e_exc_hold: if (flush_i) state_q <= e_run;
        default:    state_q <= e_run;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed while deq_v_o is high.
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      pc_mem_q[wr_ptr_q]    <= enq_pc_i;
      instr_mem_q[wr_ptr_q] <= enq_instr_i;
      md_mem_q[wr_ptr_q]    <= enq_br_metadata_fwd_i;
      exc_mem_q[wr_ptr_q]   <= enq_exc_i;
    end
  end

  assign enq_ready_o           = run & (free > cnt_w_lp'(skid_p));
  assign deq_v_o               = (count_q != '0);
  assign deq_pc_o              = pc_mem_q[rd_ptr_q];
  assign deq_instr_o           = instr_mem_q[rd_ptr_q];
  assign deq_br_metadata_fwd_o = md_mem_q[rd_ptr_q];
  assign deq_exc_o             = exc_mem_q[rd_ptr_q];
  assign count_o               = count_q;
  assign overflow_o            = overflow_q;

endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// tb/tb_bp_fe_fetch_queue.sv - directed self-checking bench for bp_fe_fetch_queue
module tb_bp_fe_fetch_queue;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        enq_v_i = 1'b0;
  logic [38:0] enq_pc_i = '0;
  logic [31:0] enq_instr_i = '0;
  logic [63:0] enq_br_metadata_fwd_i = '0;
  logic [1:0]  enq_exc_i = '0;
  logic        enq_ready_o;
  logic        deq_v_o;
  logic [38:0] deq_pc_o;
  logic [31:0] deq_instr_o;
  logic [63:0] deq_br_metadata_fwd_o;
  logic [1:0]  deq_exc_o;
  logic        deq_yumi_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [3:0]  count_o;
  logic        overflow_o;

  int total = 0;
  int bad = 0;

  bp_fe_fetch_queue dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .enq_v_i(enq_v_i), .enq_pc_i(enq_pc_i), .enq_instr_i(enq_instr_i),
    .enq_br_metadata_fwd_i(enq_br_metadata_fwd_i), .enq_exc_i(enq_exc_i),
    .enq_ready_o(enq_ready_o),
    .deq_v_o(deq_v_o), .deq_pc_o(deq_pc_o), .deq_instr_o(deq_instr_o),
    .deq_br_metadata_fwd_o(deq_br_metadata_fwd_o), .deq_exc_o(deq_exc_o),
    .deq_yumi_i(deq_yumi_i), .flush_i(flush_i),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (!reset_i && deq_yumi_i)
      assert (deq_v_o) else $error("illegal yumi while empty");
  end

  // Advance one clock; outputs are then stable 1 time unit after the edge.
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle;
    enq_v_i = 1'b0; deq_yumi_i = 1'b0; flush_i = 1'b0; enq_exc_i = 2'b00;
  endtask

  task automatic do_reset;
    idle();
    reset_i = 1'b1;
    step(); step();
    reset_i = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    #3;
    total++; if (deq_v_o !== 1'b0)     begin bad++; $display("FAIL reset_deq_v: got %b expected 0", deq_v_o); end
    total++; if (enq_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", enq_ready_o); end
    total++; if (count_o !== 4'd0)     begin bad++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    total++; if (overflow_o !== 1'b0)  begin bad++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
    step();
    reset_i = 1'b0;
  endtask

  task automatic test_basic;
    logic [38:0] pcs [3];
    pcs[0] = 39'h1000; pcs[1] = 39'h1004; pcs[2] = 39'h1008;
    for (int i = 0; i < 3; i++) begin
      enq_v_i = 1'b1; enq_pc_i = pcs[i];
      enq_instr_i = 32'hA000_0000 + 32'(i);
      enq_br_metadata_fwd_i = 64'hDEAD_0000_0000_0000 + 64'(i);
      step();
      total++; if (count_o !== 4'(i+1)) begin bad++; $display("FAIL basic_count_up: got %0d expected %0d", count_o, i+1); end
      total++; if (deq_v_o !== 1'b1) begin bad++; $display("FAIL basic_deq_v: got %b expected 1", deq_v_o); end
    end
    enq_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (deq_pc_o !== pcs[i]) begin bad++; $display("FAIL basic_order: got 0x%0h expected 0x%0h", deq_pc_o, pcs[i]); end
      total++; if (deq_instr_o !== 32'hA000_0000 + 32'(i)) begin bad++; $display("FAIL basic_instr: got 0x%0h expected 0x%0h", deq_instr_o, 32'hA000_0000 + 32'(i)); end
      total++; if (deq_br_metadata_fwd_o !== 64'hDEAD_0000_0000_0000 + 64'(i)) begin bad++; $display("FAIL basic_md: got 0x%0h", deq_br_metadata_fwd_o); end
      deq_yumi_i = 1'b1;
      step();
      deq_yumi_i = 1'b0;
      total++; if (count_o !== 4'(2-i)) begin bad++; $display("FAIL basic_count_down: got %0d expected %0d", count_o, 2-i); end
    end
    total++; if (deq_v_o !== 1'b0) begin bad++; $display("FAIL basic_empty: got %b expected 0", deq_v_o); end
  endtask

  task automatic test_fill;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      enq_v_i = 1'b1; enq_pc_i = 39'h100 + 39'(i);
      step();
      total++; if (count_o !== 4'(i+1)) begin bad++; $display("FAIL fill_count: got %0d expected %0d", count_o, i+1); end
      // ready holds while free > 2, i.e. count <= 5
      total++; if (enq_ready_o !== ((i+1) <= 5)) begin bad++; $display("FAIL fill_ready at %0d: got %b", i+1, enq_ready_o); end
      total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL fill_overflow_early: got %b expected 0", overflow_o); end
    end
    enq_pc_i = 39'h1FF;
    step();
    total++; if (count_o !== 4'd8)    begin bad++; $display("FAIL full_drop_count: got %0d expected 8", count_o); end
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL full_drop_overflow: got %b expected 1", overflow_o); end
    enq_pc_i = 39'h2FF; deq_yumi_i = 1'b1;
    step();
    enq_v_i = 1'b0; deq_yumi_i = 1'b0;
    total++; if (count_o !== 4'd7) begin bad++; $display("FAIL full_enq_deq_count: got %0d expected 7", count_o); end
    for (int i = 1; i < 8; i++) begin
      total++; if (deq_pc_o !== 39'h100 + 39'(i)) begin bad++; $display("FAIL full_drain_order: got 0x%0h expected 0x%0h", deq_pc_o, 39'h100 + 39'(i)); end
      deq_yumi_i = 1'b1;
      step();
      deq_yumi_i = 1'b0;
    end
    total++; if (deq_v_o !== 1'b0)    begin bad++; $display("FAIL full_drained: got %b expected 0", deq_v_o); end
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %b expected 1", overflow_o); end
  endtask

  task automatic test_exc_hold;
    do_reset();
    enq_v_i = 1'b1; enq_pc_i = 39'h2000; enq_exc_i = 2'd0; step();
    enq_pc_i = 39'h2004; enq_exc_i = 2'd1; step();
    total++; if (enq_ready_o !== 1'b0) begin bad++; $display("FAIL exc_ready_low: got %b expected 0", enq_ready_o); end
    enq_pc_i = 39'h2008; enq_exc_i = 2'd0; step();
    enq_v_i = 1'b0;
    total++; if (count_o !== 4'd2)     begin bad++; $display("FAIL exc_drop_count: got %0d expected 2", count_o); end
    total++; if (overflow_o !== 1'b0)  begin bad++; $display("FAIL exc_overflow: got %b expected 0", overflow_o); end
    total++; if (deq_pc_o !== 39'h2000 || deq_exc_o !== 2'd0) begin bad++; $display("FAIL exc_head0: got pc 0x%0h exc %0d expected 0x2000 exc 0", deq_pc_o, deq_exc_o); end
    deq_yumi_i = 1'b1; step(); deq_yumi_i = 1'b0;
    total++; if (deq_pc_o !== 39'h2004 || deq_exc_o !== 2'd1) begin bad++; $display("FAIL exc_head1: got pc 0x%0h exc %0d expected 0x2004 exc 1", deq_pc_o, deq_exc_o); end
    deq_yumi_i = 1'b1; step(); deq_yumi_i = 1'b0;
    total++; if (deq_v_o !== 1'b0 || enq_ready_o !== 1'b0) begin bad++; $display("FAIL exc_after_drain: got v %b ready %b expected v 0 ready 0", deq_v_o, enq_ready_o); end
    flush_i = 1'b1; step(); flush_i = 1'b0;
    total++; if (enq_ready_o !== 1'b1) begin bad++; $display("FAIL exc_flush_ready: got %b expected 1", enq_ready_o); end
  endtask

  task automatic test_flush;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      enq_v_i = 1'b1; enq_pc_i = 39'h3000 + 39'(4*i); step();
    end
    total++; if (count_o !== 4'd5 || deq_pc_o !== 39'h3000) begin bad++; $display("FAIL flush_pre: got count %0d pc 0x%0h expected 5 0x3000", count_o, deq_pc_o); end
    enq_pc_i = 39'h3FFF; deq_yumi_i = 1'b1; flush_i = 1'b1;
    step();
    idle();
    total++; if (count_o !== 4'd0) begin bad++; $display("FAIL flush_count: got %0d expected 0", count_o); end
    total++; if (deq_v_o !== 1'b0) begin bad++; $display("FAIL flush_deq_v: got %b expected 0", deq_v_o); end
    enq_v_i = 1'b1; enq_pc_i = 39'h4000; step(); enq_v_i = 1'b0;
    total++; if (count_o !== 4'd1 || deq_pc_o !== 39'h4000) begin bad++; $display("FAIL flush_after: got count %0d pc 0x%0h expected 1 0x4000", count_o, deq_pc_o); end
  endtask

  task automatic test_wrap;
    logic [38:0] exp_q[$];
    int sent, recv, cyc;
    logic do_enq, do_deq;
    do_reset();
    sent = 0; recv = 0; cyc = 0;
    while (recv < 20 && cyc < 500) begin
      do_enq = (sent < 20) && enq_ready_o && ($urandom_range(0, 1) == 1);
      do_deq = deq_v_o && ($urandom_range(0, 2) != 0);
      if (do_deq) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL wrap_unexpected_valid: got v 1 expected v 0");
          do_deq = 1'b0;
        end else begin
          chk("wrap_order", 64'(deq_pc_o), 64'(exp_q[0]));
          void'(exp_q.pop_front());
          recv++;
        end
      end
      enq_v_i = do_enq; enq_pc_i = 39'h5000 + 39'(4*sent);
      if (do_enq) begin exp_q.push_back(enq_pc_i); sent++; end
      deq_yumi_i = do_deq;
      step();
      cyc++;
      chk("wrap_count", 64'(count_o), 64'(exp_q.size()));
    end
    idle();
    chk("wrap_received", 64'(recv), 64'd20);
    chk("wrap_no_overflow", 64'(overflow_o), 64'd0);
  endtask

  task automatic test_reset_midstream;
    do_reset();
    enq_v_i = 1'b1; enq_pc_i = 39'h6100; step(); step();
    enq_v_i = 1'b0;
    chk("mid_pre_count", 64'(count_o), 64'd2);
    #2;
    reset_i = 1'b1;
    #1;
    chk("mid_async_deq_v", 64'(deq_v_o), 64'd0);
    chk("mid_async_count", 64'(count_o), 64'd0);
    chk("mid_async_ready", 64'(enq_ready_o), 64'd1);
    step();
    reset_i = 1'b0;
    enq_v_i = 1'b1; enq_pc_i = 39'h6000; step(); enq_v_i = 1'b0;
    chk("mid_first_enq_count", 64'(count_o), 64'd1);
    chk("mid_first_enq_pc", 64'(deq_pc_o), 64'h6000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_exc_hold();
    test_flush();
    test_wrap();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
